// File: rtl/dred_pkg.sv
// Shared definitions for the D-reduced function evaluator: config target
// encodings and small elaboration-time helpers.
package dred_pkg;

  // Config write targets carried on cfg_sel.
  typedef enum logic [1:0] {
    CFG_ROW  = 2'd0,
    CFG_LUT  = 2'd1,
    CFG_INV  = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

  // Widest matrix row the reset helper can describe.
  localparam int unsigned MAX_ROW_W = 256;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    clog2 = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      clog2++;
      v = v >> 1;
    end
  endfunction

  // Reset value of matrix row idx: one-hot at bit idx, so z = x[K_RED-1:0].
  function automatic logic [MAX_ROW_W-1:0] reset_row(input int unsigned idx);
    reset_row = MAX_ROW_W'(1) << idx;
  endfunction

endpackage

// File: rtl/gf2_matvec.sv
// Combinational GF(2) matrix-vector product: z[i] = parity(row[i] & x).
module gf2_matvec #(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned K_RED = 3
) (
  input  logic [N_IN-1:0]  row_i [K_RED],
  input  logic [N_IN-1:0]  x_i,
  output logic [K_RED-1:0] z_o
);

  // Each output bit is the XOR of the input bits selected by its row.
  always_comb begin
    z_o = '0;
    for (int unsigned i = 0; i < K_RED; i++) begin
      z_o[i] = ^(row_i[i] & x_i);
    end
  end

endmodule

// File: rtl/dred_eval_pipe.sv
// Two-stage valid/ready pipeline computing y[j] = lut[j][A*x] ^ inv[j],
// with the matrix A, the truth tables and the invert mask programmable.
module dred_eval_pipe
  import dred_pkg::*;
#(
  parameter int unsigned N_IN  = 5,
  parameter int unsigned K_RED = 3,
  parameter int unsigned N_OUT = 1,
  parameter int unsigned CFG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [7:0]       cfg_addr,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] y,
  output logic             idle
);

  localparam int unsigned LUT_W = 1 << K_RED;

  if (K_RED < 1 || K_RED > 8 || K_RED > N_IN) begin : g_bad_k_red
    $error("dred_eval_pipe: K_RED must be 1..8 and <= N_IN");
  end
  if (N_OUT < 1 || clog2(N_OUT) > 8) begin : g_bad_n_out
    $error("dred_eval_pipe: N_OUT must be 1..256");
  end
  if (CFG_W < N_IN || CFG_W < LUT_W || CFG_W < N_OUT) begin : g_bad_cfg_w
    $error("dred_eval_pipe: CFG_W must cover N_IN, 2^K_RED and N_OUT");
  end

  typedef logic [N_IN-1:0]  row_t;
  typedef logic [LUT_W-1:0] lut_t;

  row_t             row_q [K_RED];
  lut_t             lut_q [N_OUT];
  logic [N_OUT-1:0] inv_q;

  logic [K_RED-1:0] z;
  logic [K_RED-1:0] z_q;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [N_OUT-1:0] y_q, y_d;
  logic             s1_load, s2_load;

  // Upper cfg_data bits beyond each target's width are don't-care.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data;

  gf2_matvec #(
    .N_IN  (N_IN),
    .K_RED (K_RED)
  ) u_matvec (
    .row_i (row_q),
    .x_i   (x),
    .z_o   (z)
  );

  // Config registers: out-of-range addresses and the reserved target are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these small config arrays are reset because the function must
      // have a defined identity matrix and zero tables straight out of reset.
      for (int unsigned r = 0; r < K_RED; r++) row_q[r] <= row_t'(reset_row(r));
      for (int unsigned j = 0; j < N_OUT; j++) lut_q[j] <= '0;
      inv_q <= '0;
    end else if (cfg_we) begin
      case (cfg_sel_e'(cfg_sel))
        CFG_ROW: begin
          for (int unsigned r = 0; r < K_RED; r++)
            if (cfg_addr == 8'(r)) row_q[r] <= cfg_data[N_IN-1:0];
        end
        CFG_LUT: begin
          for (int unsigned j = 0; j < N_OUT; j++)
            if (cfg_addr == 8'(j)) lut_q[j] <= cfg_data[LUT_W-1:0];
        end
        CFG_INV: inv_q <= cfg_data[N_OUT-1:0];
        default: ;
      endcase
    end
  end

  // Handshake: s1 may accept if it is empty, or if its item can move on.
  assign in_ready = !cfg_we && (!s1_valid_q || !s2_valid_q || out_ready);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  // Next-state for the stage valids and the registered result.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned
    // and infers a latch.
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    if (s1_load)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      for (int unsigned j = 0; j < N_OUT; j++) y_d[j] = lut_q[j][z_q] ^ inv_q[j];
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q        <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      if (s1_load) z_q <= z;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign idle      = !s1_valid_q && !s2_valid_q;

endmodule

// File: tb/tb_dred_eval_pipe.sv
// Self-checking bench for dred_eval_pipe: table-driven parity vectors,
// a scoreboard queue, and hand sequences for latency, backpressure,
// illegal config writes and mid-flight reset.
module tb_dred_eval_pipe;

  localparam int unsigned N_IN  = 5;
  localparam int unsigned K_RED = 3;
  localparam int unsigned N_OUT = 1;
  localparam int unsigned CFG_W = 32;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [7:0]       cfg_addr;
  logic [CFG_W-1:0] cfg_data;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] y;
  logic             idle;

  dred_eval_pipe #(
    .N_IN  (N_IN),
    .K_RED (K_RED),
    .N_OUT (N_OUT),
    .CFG_W (CFG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] y;
  } vec_t;

  vec_t             par_tbl [6];
  logic [N_OUT-1:0] sb [$];
  logic [N_OUT-1:0] exp_y;
  int               checks = 0;
  int               failures = 0;
  int               xfer_cnt = 0;
  int               base_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Output monitor: every transfer is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got y=%0h expected no output", y);
      end else begin
        exp_y = sb.pop_front();
        check("y_scoreboard", 32'(y), 32'(exp_y));
      end
      xfer_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the write edge.
  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] addr,
                           input logic [CFG_W-1:0] data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    check("in_ready_during_cfg", 32'(in_ready), 32'd0);
    tick();
    cfg_we   = 1'b0;
    cfg_data = '0;
  endtask

  // Present one vector, push its expectation at the accepting edge.
  task automatic send_one(input logic [N_IN-1:0] xv, input logic [N_OUT-1:0] ev);
    int k;
    in_valid = 1'b1;
    x        = xv;
    k        = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (in_ready) begin
      sb.push_back(ev);
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    tick();
  endtask

  task automatic stream_tbl(input logic [N_OUT-1:0] inv_mask);
    for (int i = 0; i < 6; i++) send_one(par_tbl[i].x, par_tbl[i].y ^ inv_mask);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((!idle || sb.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    check("drain_done", 32'(idle && sb.size() == 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    par_tbl[0] = '{x: 5'b10110, y: 1'b1};
    par_tbl[1] = '{x: 5'b10111, y: 1'b0};
    par_tbl[2] = '{x: 5'b00000, y: 1'b0};
    par_tbl[3] = '{x: 5'b00001, y: 1'b1};
    par_tbl[4] = '{x: 5'b11111, y: 1'b1};
    par_tbl[5] = '{x: 5'b11000, y: 1'b0};

    rst_n     = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_addr  = '0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    x         = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_y", 32'(y), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Default config: z = x[2:0], all tables zero, so y = 0, latency 2.
    in_valid = 1'b1;
    x        = 5'b10110;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    sb.push_back(1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_out_valid_1", 32'(out_valid), 32'd0);
    check("lat_idle_busy", 32'(idle), 32'd0);
    @(negedge clk);
    check("lat_out_valid_2", 32'(out_valid), 32'd1);
    tick();
    check("idle_after", 32'(idle), 32'd1);

    // Parity of all five inputs; high cfg_data bits must be ignored.
    cfg_write(2'd0, 8'd0, 32'hFFFF_FFFF);
    cfg_write(2'd0, 8'd1, 32'h0);
    cfg_write(2'd0, 8'd2, 32'h0);
    cfg_write(2'd1, 8'd0, 32'hABCD_EF02);
    @(negedge clk);
    check("in_ready_after_cfg", 32'(in_ready), 32'd1);
    tick();
    stream_tbl(1'b0);
    drain();

    // Same function, complemented.
    cfg_write(2'd2, 8'd0, 32'h1);
    stream_tbl(1'b1);
    drain();

    // Backpressure: two items fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    send_one(par_tbl[0].x, par_tbl[0].y ^ 1'b1);
    send_one(par_tbl[1].x, par_tbl[1].y ^ 1'b1);
    in_valid = 1'b1;
    x        = par_tbl[2].x;
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_y_head", 32'(y), 32'(par_tbl[0].y ^ 1'b1));
    for (int s = 0; s < 2; s++) begin
      tick();
      @(negedge clk);
      check("bp_in_ready_stall", 32'(in_ready), 32'd0);
      check("bp_y_hold", 32'(y), 32'(par_tbl[0].y ^ 1'b1));
      check("bp_out_valid_hold", 32'(out_valid), 32'd1);
    end
    tick();
    out_ready = 1'b1;
    base_cnt  = xfer_cnt;
    send_one(par_tbl[2].x, par_tbl[2].y ^ 1'b1);
    send_one(par_tbl[3].x, par_tbl[3].y ^ 1'b1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("bp_no_gap_count", 32'(xfer_cnt - base_cnt), 32'd4);
    tick();
    drain();

    // Illegal writes must leave the parity+invert config untouched.
    cfg_write(2'd3, 8'd0, 32'h0);
    cfg_write(2'd0, 8'(K_RED), 32'h0);
    cfg_write(2'd1, 8'(N_OUT), 32'h0);
    @(negedge clk);
    check("in_ready_after_illegal", 32'(in_ready), 32'd1);
    tick();
    stream_tbl(1'b1);
    drain();

    // Reset with two items in flight.
    out_ready = 1'b0;
    send_one(5'b10111, 1'b1);
    send_one(5'b10110, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_y", 32'(y), 32'd1);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_y", 32'(y), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send_one(5'b10110, 1'b0);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dred_eval_pipe.md
Name: dred_eval_pipe

Overview:
- Parametrised, pipelined, run-time programmable evaluator for D-reduced (autosymmetric) Boolean functions.
- Each function is computed as f(x) = g(A·x) ^ inv:
  - A is a K_RED x N_IN matrix over GF(2).
  - g is a 2^K_RED-entry truth table, one per output.
  - inv is a per-output complement bit.
- Generalises the fixed single-output 5-input restriction blocks: any width, multiple outputs, reloadable function.
- Adds a valid/ready streaming interface. Sits after the restriction/benchmark stimulus generator and before the result comparator.

Parameters:
- N_IN, 5: input vector width (>=1).
- K_RED, 3: reduced-space dimension (1..8, <= N_IN).
- N_OUT, 1: number of outputs (>=1).
- CFG_W, 32: config data width. Elaboration error unless CFG_W >= max(N_IN, 2^K_RED, N_OUT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  config target: 0 = matrix row, 1 = truth table, 2 = invert mask, 3 = reserved.
- cfg_addr  in  8  row index (sel 0) or output index (sel 1).
- cfg_data  in  CFG_W  write data, LSB-aligned.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts x this cycle.
- x  in  N_IN  input vector.
- out_valid  out  1  y valid.
- out_ready  in  1  downstream accepts y.
- y  out  N_OUT  function outputs.
- idle  out  1  both pipeline stages empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; all state clears immediately on rst_n low.
- Reset values:
  - Matrix row i = one-hot bit i, i.e. z = x[K_RED-1:0].
  - All truth tables = 0; invert mask = 0.
  - s1_valid = s2_valid = 0, so out_valid = 0 and idle = 1.
  - y = 0; in_ready = 1 whenever cfg_we = 0.
- Config writes:
  - Take effect at the clk edge where cfg_we = 1.
  - sel 0: row[cfg_addr] <= cfg_data[N_IN-1:0].
  - sel 1: lut[cfg_addr] <= cfg_data[2^K_RED-1:0].
  - sel 2: inv <= cfg_data[N_OUT-1:0].
  - Ignored if sel = 3, if sel 0 and cfg_addr >= K_RED, or if sel 1 and cfg_addr >= N_OUT.
  - Unused high cfg_data bits are ignored.
- While cfg_we = 1, in_ready = 0 (no new accepts).
- In-flight items are NOT protected from config writes:
  - Stage 1 uses the matrix at its capture edge.
  - Stage 2 uses the LUT and inv at its capture edge.
  - Software drains (waits for idle = 1) before reprogramming.
- Stage 1 (capture on in_valid & in_ready): z[i] = XOR-reduce(row[i] & x); s1_valid <= 1.
- Stage 2: y[j] <= lut[j][z] ^ inv[j]; s2_valid <= 1. out_valid = s2_valid, and y is registered.
- Advance rules (full-throughput pipeline, no bubbles when out_ready = 1):
  - s2 loads when s1_valid & (!s2_valid | out_ready).
  - s1 loads when in_ready & in_valid.
  - in_ready = !cfg_we & (!s1_valid | !s2_valid | out_ready).
- Stage valid updates:
  - s2_valid clears on out_valid & out_ready with no new load.
  - s1_valid clears when s1 moves to s2 with no new accept.
- Latency: accept at edge t gives out_valid at edge t+2 when out_ready = 1. Sustained throughput is 1 item/cycle.
- Backpressure: with out_ready = 0, at most 2 items are held. in_ready falls once s1 and s2 are both valid. y and out_valid stay stable until the transfer.
- Simultaneous events: accept, s1->s2 move and output transfer in the same cycle are all legal. Items are never duplicated or dropped, and order is preserved.
- Reset mid-operation: all in-flight items are discarded and configuration returns to reset values.
- idle = !s1_valid & !s2_valid.

Decomposition:
- Package dred_pkg holds:
  - cfg_sel encodings: CFG_ROW = 0, CFG_LUT = 1, CFG_INV = 2.
  - Function clog2.
  - Reset-row helper.
- Sub-module gf2_matvec (purely combinational, params N_IN, K_RED) computes z from the matrix rows and x.
- The top level holds the config registers, both pipeline stages and the handshake.

Test Plan:
- Reset, then with defaults stream x = 5'b10110 with out_ready = 1 -> out_valid two cycles later, y = 0; idle returns to 1.
- Parity function:
  - Config: row0 = 5'b11111, lut0 = 8'b00000010, rows 1-2 = 0.
  - Stimulus: x = 5'b10110, then 5'b10111.
  - Required response: y = 1, then 0.
- Invert mask: add inv = 1 to the parity config -> the same inputs give y = 0, then 1.
- Backpressure:
  - Stream 4 vectors with out_ready low for 3 cycles.
  - Required: in_ready drops after 2 accepts and y holds its value.
  - On release, all 4 results arrive in order with no gap.
- Illegal config writes:
  - Writes with sel = 3, row addr = K_RED, or LUT addr = N_OUT.
  - Required: configuration unchanged (the parity result is still correct) and in_ready = 0 only during the cfg_we cycles.
- Async reset pulse asserted while 2 items are in flight -> out_valid = 0 immediately, y = 0, and config returns to defaults (the parity input now gives 0).
